fab_reset_sequencer: RTL and testbench
======================================

# fab_reset_sequencer

Reset sequencer clocked by the fabric copy of the 25/50 MHz RC oscillator (RCOSC_25_50MHZ_O2F, global-buffered). It sits directly downstream of the system-block oscillator. It holds fabric logic in reset until the fabric CCC reports a stable lock, then releases the fabric reset and the peripheral reset in staggered order. It re-asserts reset on lock loss or on a software request.

## Interface
- LOCK_FILT_CYC, 1024: consecutive cycles of synchronized lock required before release.
- PERIPH_DLY_CYC, 50000: cycles between FAB_RESET release and PERIPH_RESET_N release (1 ms at 50 MHz).
- SW_PULSE_CYC, 64: minimum reset hold for a software request.
- CNT_W, 16: width of the shared delay counter. Must hold max(param)-1.

Ports:
- CLK_BASE  in  1  50 MHz fabric clock from RCOSC_25_50MHZ_O2F.
- RESET  in  1  asynchronous, active-high. Asserted while the oscillator or POR is not valid.
- FAB_PLL_LOCK  in  1  CCC lock, asynchronous to CLK_BASE.
- SW_RESET_REQ  in  1  single-cycle synchronous request pulse.
- FAB_RESET  out  1  active-high fabric reset.
- PERIPH_RESET_N  out  1  active-low peripheral reset.
- INIT_DONE  out  1  high only in RUN.
- STATE  out  3  current state encoding (debug).
- LOCK_LOSS_CNT  out  8  saturating count of lock-loss events.

## Operation
- **Reset synchronizer:** RESET passes through a 2-flop synchronizer with asynchronous assert and synchronous deassert. The internal reset rst_s drives all other flops.
- **Lock synchronizer:** FAB_PLL_LOCK passes through a 2-flop synchronizer, giving lock_s. The FSM uses only lock_s.
- **Reset values:** FAB_RESET=1, PERIPH_RESET_N=0, INIT_DONE=0, STATE=0, LOCK_LOSS_CNT=0, counter=0.
- **States** (STATE encoding in parentheses):
  - HOLD (0): occupied while rst_s is asserted. Leaves to WAIT_LOCK on the first edge with rst_s low.
  - WAIT_LOCK (1): FAB_RESET=1, PERIPH_RESET_N=0. Goes to FILTER when lock_s=1; the counter is cleared on entry.
  - FILTER (2): outputs as in WAIT_LOCK. If lock_s=0, return to WAIT_LOCK. If counter==LOCK_FILT_CYC-1, go to FAB_REL and clear the counter. Otherwise increment the counter.
  - FAB_REL (3): FAB_RESET=0, PERIPH_RESET_N=0. When counter==PERIPH_DLY_CYC-1, go to RUN. Otherwise increment the counter.
  - RUN (4): FAB_RESET=0, PERIPH_RESET_N=1, INIT_DONE=1.
  - SW_HOLD (5): FAB_RESET=1, PERIPH_RESET_N=0. When counter==SW_PULSE_CYC-1, go to WAIT_LOCK. Otherwise increment the counter.
- **Lock loss:** lock_s=0 while in FAB_REL or RUN causes a transition to WAIT_LOCK and increments LOCK_LOSS_CNT, saturating at 255.
- **Software request:** SW_RESET_REQ=1 while in FAB_REL or RUN causes a transition to SW_HOLD and clears the counter. The request is ignored in all other states. It is not queued.
- **Simultaneous events:** if lock loss and SW_RESET_REQ occur in the same cycle, lock loss wins. The FSM goes to WAIT_LOCK and LOCK_LOSS_CNT increments.
- **Lock loss in SW_HOLD:** not counted. SW_HOLD always runs its full length.
- **Unused encodings (6, 7):** the FSM recovers to WAIT_LOCK on the next edge.

## Timing
- All outputs are registered and decoded from the next state. Each output changes on the same edge on which the FSM enters the corresponding state.
- **Release latency:** RESET falls, then the FSM enters WAIT_LOCK on the 3rd rising edge of CLK_BASE.
- **Lock latency:** FAB_PLL_LOCK is first sampled high at edge e0. lock_s is high after e1. The FSM enters FILTER at e2.
- **FAB_RESET release:** FAB_RESET falls at e(2+LOCK_FILT_CYC).
- **Peripheral release:** PERIPH_RESET_N and INIT_DONE rise at e(2+LOCK_FILT_CYC+PERIPH_DLY_CYC).
- **Lock drop:** FAB_PLL_LOCK is sampled low at edge d0. Resets re-assert at d2, i.e. lock_s latency plus 1 edge.
- **RESET mid-operation:** FAB_RESET=1, PERIPH_RESET_N=0 and INIT_DONE=0 immediately and asynchronously. LOCK_LOSS_CNT clears.
- **Software pulse:** the request is registered at edge s0. FAB_RESET=1 from s0. The FSM re-enters WAIT_LOCK at s0+SW_PULSE_CYC.

## Test plan
Parameters for all scenarios: LOCK_FILT_CYC=4, PERIPH_DLY_CYC=8, SW_PULSE_CYC=3.

1. **Power-up:** release RESET with FAB_PLL_LOCK held 1 -> STATE=1 at edge 3. FAB_RESET falls 6 edges after the first lock sample (e6). PERIPH_RESET_N and INIT_DONE rise at e14.
2. **Glitchy lock:** lock high 3 cycles, low 1, then high -> FILTER aborts to WAIT_LOCK. FAB_RESET stays 1 until 4 consecutive lock_s cycles. LOCK_LOSS_CNT=0.
3. **Lock loss in RUN:** drop FAB_PLL_LOCK -> FAB_RESET=1, PERIPH_RESET_N=0, INIT_DONE=0 at d2. LOCK_LOSS_CNT=1. Re-lock repeats scenario 1 timing.
4. **SW request in RUN:** 1-cycle SW_RESET_REQ -> FAB_RESET=1 for exactly 3 cycles in SW_HOLD, then WAIT_LOCK. RUN is reached again 2+4+8 edges later. LOCK_LOSS_CNT is unchanged.
5. **Simultaneous SW request and lock loss in FAB_REL:** -> STATE=1 (not 5) and LOCK_LOSS_CNT increments. SW_RESET_REQ in WAIT_LOCK has no effect.
6. **Counter saturation and reset:** 300 lock-loss events -> LOCK_LOSS_CNT=255. Asserting RESET mid-FAB_REL -> all outputs at reset values in the same cycle, with no clock edge required.

Source files
------------

// File: rtl/fab_reset_sequencer.sv
// fab_reset_sequencer: holds the fabric in reset until the CCC lock is stable,
// then releases FAB_RESET and, after a fixed delay, PERIPH_RESET_N.
// Lock loss or a software request re-asserts the resets.
module fab_reset_sequencer #(
   parameter int unsigned LOCK_FILT_CYC  = 1024,
   parameter int unsigned PERIPH_DLY_CYC = 50000,
   parameter int unsigned SW_PULSE_CYC   = 64,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       CLK_BASE,
   input  logic       RESET,
   input  logic       FAB_PLL_LOCK,
   input  logic       SW_RESET_REQ,
   output logic       FAB_RESET,
   output logic       PERIPH_RESET_N,
   output logic       INIT_DONE,
   output logic [2:0] STATE,
   output logic [7:0] LOCK_LOSS_CNT
);

   localparam int unsigned ST_W    = 3;
   localparam int unsigned LOSS_W  = 8;

   localparam logic [ST_W-1:0] ST_HOLD      = 3'd0;
   localparam logic [ST_W-1:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [ST_W-1:0] ST_FILTER    = 3'd2;
   localparam logic [ST_W-1:0] ST_FAB_REL   = 3'd3;
   localparam logic [ST_W-1:0] ST_RUN       = 3'd4;
   localparam logic [ST_W-1:0] ST_SW_HOLD   = 3'd5;

   // Terminal counts for the shared delay counter
   localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(LOCK_FILT_CYC - 1);
   localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_PULSE_CYC - 1);
   localparam logic [LOSS_W-1:0] LOSS_MAX   = {LOSS_W{1'b1}};

   logic rst_meta_q;
   logic rst_s_q;
   logic lock_meta_q;
   logic lock_s_q;

   logic [ST_W-1:0]   state_q,          state_d;
   logic [CNT_W-1:0]  cnt_q,            cnt_d;
   logic [LOSS_W-1:0] loss_cnt_q,       loss_cnt_d;
   logic              fab_reset_q,      fab_reset_d;
   logic              periph_reset_n_q, periph_reset_n_d;
   logic              init_done_q,      init_done_d;

   // Reset synchronizer: asserts asynchronously, releases after two edges
   always_ff @(posedge CLK_BASE or posedge RESET) begin
      if (RESET) begin
         rst_meta_q <= 1'b1;
         rst_s_q    <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_s_q    <= rst_meta_q;
      end
   end

   // Lock synchronizer: FAB_PLL_LOCK is asynchronous to CLK_BASE
   always_ff @(posedge CLK_BASE or posedge rst_s_q) begin
      if (rst_s_q) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= FAB_PLL_LOCK;
         lock_s_q    <= lock_meta_q;
      end
   end

   // Next-state, delay counter and lock-loss counter
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      loss_cnt_d = loss_cnt_q;

      case (state_q)
         ST_HOLD: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end

         ST_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = ST_FILTER;
               cnt_d   = '0;
            end
         end

         ST_FILTER: begin
            if (!lock_s_q) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == FILT_LAST) begin
               state_d = ST_FAB_REL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_FAB_REL, ST_RUN: begin
            // Lock loss has priority over a software request
            if (!lock_s_q) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               if (loss_cnt_q != LOSS_MAX) begin
                  loss_cnt_d = loss_cnt_q + LOSS_W'(1);
               end
            end else if (SW_RESET_REQ) begin
               state_d = ST_SW_HOLD;
               cnt_d   = '0;
            end else if (state_q == ST_FAB_REL) begin
               if (cnt_q == PERIPH_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_SW_HOLD: begin
            // Runs its full length regardless of lock
            if (cnt_q == SW_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the next state so outputs change with the state
   always_comb begin
      fab_reset_d      = 1'b1;
      periph_reset_n_d = 1'b0;
      init_done_d      = 1'b0;
      if (state_d == ST_FAB_REL) begin
         fab_reset_d = 1'b0;
      end else if (state_d == ST_RUN) begin
         fab_reset_d      = 1'b0;
         periph_reset_n_d = 1'b1;
         init_done_d      = 1'b1;
      end
   end

   // FSM, counters and registered outputs
   always_ff @(posedge CLK_BASE or posedge rst_s_q) begin
      if (rst_s_q) begin
         state_q          <= ST_HOLD;
         cnt_q            <= '0;
         loss_cnt_q       <= '0;
         fab_reset_q      <= 1'b1;
         periph_reset_n_q <= 1'b0;
         init_done_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         loss_cnt_q       <= loss_cnt_d;
         fab_reset_q      <= fab_reset_d;
         periph_reset_n_q <= periph_reset_n_d;
         init_done_q      <= init_done_d;
      end
   end

   assign FAB_RESET      = fab_reset_q;
   assign PERIPH_RESET_N = periph_reset_n_q;
   assign INIT_DONE      = init_done_q;
   assign STATE          = state_q;
   assign LOCK_LOSS_CNT  = loss_cnt_q;

endmodule

// File: tb/tb_fab_reset_sequencer.sv
// Testbench for fab_reset_sequencer with short delays (4/8/3).
module tb_fab_reset_sequencer;

   logic       clk;
   logic       rst;
   logic       lock;
   logic       sw;
   logic       fab_reset;
   logic       periph_reset_n;
   logic       init_done;
   logic [2:0] state;
   logic [7:0] loss_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic       lock;
      logic       sw;
      logic       fab;
      logic       pn;
      logic       init;
      logic [2:0] st;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[64];
   int   n_vec = 0;

   fab_reset_sequencer #(
      .LOCK_FILT_CYC (4),
      .PERIPH_DLY_CYC(8),
      .SW_PULSE_CYC  (3),
      .CNT_W         (16)
   ) dut (
      .CLK_BASE      (clk),
      .RESET         (rst),
      .FAB_PLL_LOCK  (lock),
      .SW_RESET_REQ  (sw),
      .FAB_RESET     (fab_reset),
      .PERIPH_RESET_N(periph_reset_n),
      .INIT_DONE     (init_done),
      .STATE         (state),
      .LOCK_LOSS_CNT (loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {2'b00, fab_reset, periph_reset_n, init_done, state, loss_cnt};
   endfunction

   function automatic logic [15:0] pack_exp(logic f, logic p, logic i, logic [2:0] s, logic [7:0] c);
      return {2'b00, f, p, i, s, c};
   endfunction

   // Append n identical rows: inputs then outputs expected after the edge
   task automatic add(input int n, input logic r, input logic l, input logic s,
                      input logic f, input logic p, input logic i,
                      input logic [2:0] st, input logic [7:0] c);
      for (int k = 0; k < n; k++) begin
         vecs[n_vec].rst  = r;
         vecs[n_vec].lock = l;
         vecs[n_vec].sw   = s;
         vecs[n_vec].fab  = f;
         vecs[n_vec].pn   = p;
         vecs[n_vec].init = i;
         vecs[n_vec].st   = st;
         vecs[n_vec].cnt  = c;
         n_vec++;
      end
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, input string name);
      int n;
      n = 0;
      while (state !== target && n < budget) begin
         tick();
         n++;
      end
      if (state !== target) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, state %0d expected %0d", name, state, target);
      end
   endtask

   // Reset pulse then release; WAIT_LOCK is entered on the 3rd edge
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("rel_latency_edge2", 16'(state), 16'd0);
      tick();
      check("rel_latency_edge3", 16'(state), 16'd1);
   endtask

   initial begin
      rst  = 1'b1;
      lock = 1'b1;
      sw   = 1'b0;
      tick();
      tick();

      // Power-up with lock held high
      add(1, 1,1,0, 1,0,0, 3'd0, 8'd0);
      add(2, 0,1,0, 1,0,0, 3'd0, 8'd0);
      add(2, 0,1,0, 1,0,0, 3'd1, 8'd0);
      add(4, 0,1,0, 1,0,0, 3'd2, 8'd0);
      add(8, 0,1,0, 0,0,0, 3'd3, 8'd0);
      add(2, 0,1,0, 0,1,1, 3'd4, 8'd0);
      // Lock loss in RUN: resets re-assert at d2, then re-lock
      add(2, 0,0,0, 0,1,1, 3'd4, 8'd0);
      add(1, 0,0,0, 1,0,0, 3'd1, 8'd1);
      add(2, 0,1,0, 1,0,0, 3'd1, 8'd1);
      add(4, 0,1,0, 1,0,0, 3'd2, 8'd1);
      add(8, 0,1,0, 0,0,0, 3'd3, 8'd1);
      add(1, 0,1,0, 0,1,1, 3'd4, 8'd1);
      // Software request in RUN: 3 cycles of SW_HOLD, then back to RUN
      add(1, 0,1,1, 1,0,0, 3'd5, 8'd1);
      add(2, 0,1,0, 1,0,0, 3'd5, 8'd1);
      add(1, 0,1,0, 1,0,0, 3'd1, 8'd1);
      add(4, 0,1,0, 1,0,0, 3'd2, 8'd1);
      add(8, 0,1,0, 0,0,0, 3'd3, 8'd1);
      add(2, 0,1,0, 0,1,1, 3'd4, 8'd1);

      for (int i = 0; i < n_vec; i++) begin
         rst  = vecs[i].rst;
         lock = vecs[i].lock;
         sw   = vecs[i].sw;
         tick();
         check($sformatf("vec%0d", i), outs(),
               pack_exp(vecs[i].fab, vecs[i].pn, vecs[i].init, vecs[i].st, vecs[i].cnt));
      end

      // Glitchy lock: high 3, low 1, high; filter restarts
      lock = 1'b0;
      do_reset();
      lock = 1'b1;
      tick();
      tick();
      tick();
      check("glitch_filter", 16'(state), 16'd2);
      lock = 1'b0;
      tick();
      lock = 1'b1;
      tick();
      tick();
      check("glitch_abort", 16'(state), 16'd1);
      tick();
      tick();
      tick();
      tick();
      check("glitch_hold", outs(), pack_exp(1'b1, 1'b0, 1'b0, 3'd2, 8'd0));
      tick();
      check("glitch_release", outs(), pack_exp(1'b0, 1'b0, 1'b0, 3'd3, 8'd0));

      // Simultaneous lock loss and SW request in FAB_REL: lock loss wins
      lock = 1'b1;
      do_reset();
      wait_state(3'd3, 20, "reach_fab_rel");
      tick();
      lock = 1'b0;
      tick();
      tick();
      check("fab_rel_before_d2", 16'(state), 16'd3);
      sw = 1'b1;
      tick();
      sw = 1'b0;
      check("simul_loss_wins", outs(), pack_exp(1'b1, 1'b0, 1'b0, 3'd1, 8'd1));
      sw = 1'b1;
      tick();
      sw = 1'b0;
      check("sw_ignored_wait", 16'(state), 16'd1);
      tick();
      check("sw_not_queued", outs(), pack_exp(1'b1, 1'b0, 1'b0, 3'd1, 8'd1));

      // Saturating lock-loss counter
      lock = 1'b0;
      do_reset();
      check("cnt_cleared", 16'(loss_cnt), 16'd0);
      for (int i = 0; i < 300; i++) begin
         lock = 1'b1;
         wait_state(3'd3, 20, "sat_fab_rel");
         lock = 1'b0;
         wait_state(3'd1, 10, "sat_wait_lock");
         if (i == 9)   check("cnt_10", 16'(loss_cnt), 16'd10);
         if (i == 254) check("cnt_255", 16'(loss_cnt), 16'd255);
      end
      check("cnt_saturated", 16'(loss_cnt), 16'd255);

      // RESET mid-FAB_REL: outputs return to reset values with no clock edge
      lock = 1'b1;
      wait_state(3'd3, 20, "reach_fab_rel2");
      tick();
      check("pre_async", outs(), pack_exp(1'b0, 1'b0, 1'b0, 3'd3, 8'd255));
      rst = 1'b1;
      #2;
      check("async_reset", outs(), pack_exp(1'b1, 1'b0, 1'b0, 3'd0, 8'd0));
      tick();
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
